// File: rtl/fetch_sequencer.sv
// Fetch front end: 8-bit program counter plus one-hot T-state ring counter.
// Define FETCH_SEQ_EXTENDED_FETCH_EN to enable the 10-state extended fetch cycle.
module fetch_sequencer (
    input  logic       clk,
    input  logic       clear,
    input  logic       count,
    input  logic       load,
    input  logic [7:0] jump_address,
    output logic [7:0] address,
    input  logic       enable,
    input  logic       extended_fetch,
    output logic [9:0] t_state
);

`ifdef FETCH_SEQ_EXTENDED_FETCH_EN
    localparam int unsigned NumT = 10;
`else
    localparam int unsigned NumT = 6;
`endif

    logic [7:0]      pc_d, pc_q;
    logic [NumT-1:0] ring_d, ring_q;
    logic            ring_valid;
    logic            ring_wrap;

    // Program counter: clear > load > count > hold.
    always_comb begin
        pc_d = pc_q;
        if (clear) begin
            pc_d = 8'h00;
        end else if (load) begin
            pc_d = jump_address;
        end else if (count) begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_comb begin
        ring_valid = (ring_q != '0) && ((ring_q & (ring_q - NumT'(1))) == '0);
`ifdef FETCH_SEQ_EXTENDED_FETCH_EN
        // Dropping extended_fetch while in T6..T9 also ends the cycle.
        ring_wrap = ring_q[9] | (~extended_fetch & (ring_q[5] | (|ring_q[9:6])));
`else
        ring_wrap = ring_q[5];
`endif
    end

    // Ring counter: clear or an illegal code forces T0; otherwise advance on enable.
    always_comb begin
        ring_d = ring_q;
        if (clear || !ring_valid) begin
            ring_d = NumT'(1);
        end else if (enable) begin
            ring_d = ring_wrap ? NumT'(1) : (ring_q << 1);
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        ring_q <= ring_d;
    end

`ifndef FETCH_SEQ_EXTENDED_FETCH_EN
    logic unused_extended_fetch;
    assign unused_extended_fetch = extended_fetch;
`endif

    assign address = pc_q;
    assign t_state = 10'(ring_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; expectations follow the
// build configuration selected by FETCH_SEQ_EXTENDED_FETCH_EN.
module tb_fetch_sequencer;

    logic       clk;
    logic       clear;
    logic       count;
    logic       load;
    logic [7:0] jump_address;
    logic [7:0] address;
    logic       enable;
    logic       extended_fetch;
    logic [9:0] t_state;

    int unsigned n_checks;
    int unsigned n_fails;

    fetch_sequencer dut (
        .clk           (clk),
        .clear         (clear),
        .count         (count),
        .load          (load),
        .jump_address  (jump_address),
        .address       (address),
        .enable        (enable),
        .extended_fetch(extended_fetch),
        .t_state       (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] t_of(input int n);
        return 16'(10'b1 << n);
    endfunction

`ifdef FETCH_SEQ_EXTENDED_FETCH_EN
    int ext_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    int mid_t       = 7;
    int after_drop  = 0;
`else
    int ext_seq[10] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
    int mid_t       = 1;
    int after_drop  = 2;
`endif
    int short_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    logic [7:0] cnt_a[3] = '{8'hA6, 8'hA7, 8'hA8};
    logic [7:0] cnt_b[3] = '{8'hB6, 8'hB7, 8'hB8};

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clear = 1'b1; count = 1'b0; load = 1'b0; jump_address = 8'h00;
        enable = 1'b0; extended_fetch = 1'b0;
        step();
        check_eq("reset_addr", 16'(address), 16'h0000);
        check_eq("reset_t", 16'(t_state), t_of(0));
        clear = 1'b0;

        load = 1'b1; jump_address = 8'hA5;
        step();
        check_eq("load_a5", 16'(address), 16'h00A5);
        load = 1'b0; count = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("count_a", 16'(address), 16'(cnt_a[i]));
        end
        count = 1'b0;
        step();
        check_eq("hold_addr", 16'(address), 16'h00A8);
        check_eq("t_idle", 16'(t_state), t_of(0));

        load = 1'b1; jump_address = 8'hB5;
        step();
        check_eq("load_b5", 16'(address), 16'h00B5);
        load = 1'b0; count = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("count_b", 16'(address), 16'(cnt_b[i]));
        end
        count = 1'b0; clear = 1'b1;
        step();
        check_eq("clear_addr", 16'(address), 16'h0000);
        clear = 1'b0;

        load = 1'b1; count = 1'b1; jump_address = 8'h3C;
        step();
        check_eq("load_over_count", 16'(address), 16'h003C);
        count = 1'b0; jump_address = 8'hFF;
        step();
        check_eq("load_ff", 16'(address), 16'h00FF);
        load = 1'b0; count = 1'b1;
        step();
        check_eq("wrap_00", 16'(address), 16'h0000);
        count = 1'b0;

        // Ring counter, short cycle; PC keeps counting independently.
        enable = 1'b1; extended_fetch = 1'b0; count = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("short_ring", 16'(t_state), t_of(short_seq[i]));
        end
        check_eq("pc_indep", 16'(address), 16'h0007);
        count = 1'b0; enable = 1'b0;
        step();
        check_eq("hold_t1_a", 16'(t_state), t_of(1));
        step();
        check_eq("hold_t1_b", 16'(t_state), t_of(1));

        clear = 1'b1;
        step();
        check_eq("clear_ring", 16'(t_state), t_of(0));
        clear = 1'b0; extended_fetch = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("ext_ring", 16'(t_state), t_of(ext_seq[i]));
        end

        // Clear mid-cycle, with enable still high.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check_eq("mid_reach", 16'(t_state), t_of(mid_t));
        clear = 1'b1;
        step();
        check_eq("mid_clear", 16'(t_state), t_of(0));
        clear = 1'b0;

        // Drop extended_fetch in T7 (extended build).
        for (int i = 0; i < 7; i++) step();
        check_eq("drop_reach", 16'(t_state), t_of(mid_t));
        extended_fetch = 1'b0; enable = 1'b0;
        step();
        check_eq("drop_hold", 16'(t_state), t_of(mid_t));
        enable = 1'b1;
        step();
        check_eq("drop_next", 16'(t_state), t_of(after_drop));
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
